// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 keyboard receiver and WASD/arrow/E key decoder, clk domain.
// Optional PS2_PARITY_CHECK_EN adds odd-parity checking of each received frame.
module ps2_key_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 130000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [3:0] key,
   output logic [7:0] scancode,
   output logic       code_valid,
   output logic       frame_err
);
   // state  | meaning
   // IDLE   | waiting for a start bit on a filtered falling edge
   // SHIFT  | collecting data, parity and stop bits; timeout armed
   // CHECK  | one cycle: validate stop/parity, publish byte, decode key
   typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

   localparam logic [3:0] key_NONE = 4'h0;
   localparam logic [3:0] key_A    = 4'h1;
   localparam logic [3:0] key_D    = 4'h2;
   localparam logic [3:0] key_W    = 4'h3;
   localparam logic [3:0] key_S    = 4'h4;
   localparam logic [3:0] key_E    = 4'h5;

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          filt_q;
   logic [FW-1:0] filt_cnt_q;
   logic          fall_d;
   logic          frame_ok_d;
   logic [3:0]    map_d;

   state_t        state_q;
   logic [3:0]    bit_cnt_q;
   logic [9:0]    sh_q;
   logic [TW-1:0] to_cnt_q;
   logic          brk_q, ext_q;
   logic [3:0]    key_q;
   logic [7:0]    scancode_q;
   logic          code_valid_q, frame_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         filt_q     <= 1'b1;
         filt_cnt_q <= FW'(FILTER_LEN - 1);
      end else begin
         clk_s1_q <= ps2_clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= ps2_data;
         dat_s2_q <= dat_s1_q;
         // down-counter runs only while the synchronised clock disagrees with the filtered one
         if (clk_s2_q == filt_q) begin
            filt_cnt_q <= FW'(FILTER_LEN - 1);
         end else if (filt_cnt_q == '0) begin
            filt_q     <= clk_s2_q;
            filt_cnt_q <= FW'(FILTER_LEN - 1);
         end else begin
            filt_cnt_q <= filt_cnt_q - 1'b1;
         end
      end
   end

   assign fall_d = filt_q && !clk_s2_q && (filt_cnt_q == '0);

`ifdef PS2_PARITY_CHECK_EN
   assign frame_ok_d = sh_q[9] && (^sh_q[8:0]);
`else
   assign frame_ok_d = sh_q[9];
`endif

   always_comb begin
      map_d = key_NONE;
      case ({ext_q, sh_q[7:0]})
         9'h01C:  map_d = key_A;
         9'h023:  map_d = key_D;
         9'h01D:  map_d = key_W;
         9'h01B:  map_d = key_S;
         9'h024:  map_d = key_E;
         9'h16B:  map_d = key_A;
         9'h174:  map_d = key_D;
         9'h175:  map_d = key_W;
         9'h172:  map_d = key_S;
         default: map_d = key_NONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         sh_q         <= '0;
         to_cnt_q     <= '0;
         brk_q        <= 1'b0;
         ext_q        <= 1'b0;
         key_q        <= key_NONE;
         scancode_q   <= '0;
         code_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         code_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (fall_d && !dat_s2_q) begin
                  state_q   <= SHIFT;
                  bit_cnt_q <= 4'd1;
                  to_cnt_q  <= TW'(TIMEOUT_CYCLES - 1);
               end
            end
            SHIFT: begin
               if (fall_d) begin
                  sh_q      <= {dat_s2_q, sh_q[9:1]};
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  to_cnt_q  <= TW'(TIMEOUT_CYCLES - 1);
                  if (bit_cnt_q == 4'd10) state_q <= CHECK;
               end else if (to_cnt_q == '0) begin
                  frame_err_q <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  to_cnt_q <= to_cnt_q - 1'b1;
               end
            end
            CHECK: begin
               state_q <= IDLE;
               if (!frame_ok_d) begin
                  frame_err_q <= 1'b1;
               end else begin
                  scancode_q   <= sh_q[7:0];
                  code_valid_q <= 1'b1;
                  if (sh_q[7:0] == 8'hE0) begin
                     ext_q <= 1'b1;
                  end else if (sh_q[7:0] == 8'hF0) begin
                     brk_q <= 1'b1;
                  end else begin
                     if (!brk_q) begin
                        if (map_d != key_NONE) key_q <= map_d;
                     end else if (map_d != key_NONE && map_d == key_q) begin
                        key_q <= key_NONE;
                     end
                     brk_q <= 1'b0;
                     ext_q <= 1'b0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign key        = key_q;
   assign scancode   = scancode_q;
   assign code_valid = code_valid_q;
   assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: a key-state model predicts each
// accepted byte or frame error, and a monitor checks them as the DUT emits them.
module tb_ps2_key_decoder;
   localparam int TO   = 1000;
   localparam int HALF = 20;

   typedef struct {
      logic       is_err;
      logic [7:0] sc;
      logic [3:0] key;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [3:0] key;
   logic [7:0] scancode;
   logic       code_valid, frame_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t q[$];

   logic [3:0] map0 [logic [7:0]];
   logic [3:0] map1 [logic [7:0]];
   logic [3:0] m_key = 4'h0;
   logic       m_brk = 1'b0, m_ext = 1'b0;

   ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key(key), .scancode(scancode), .code_valid(code_valid), .frame_err(frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Monitor: every output pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && (code_valid || frame_err)) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: code_valid=%0b frame_err=%0b scancode=%h key=%h", code_valid, frame_err, scancode, key);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.is_err) begin
               if (!frame_err || code_valid || key !== e.key) begin
                  errors++;
                  $display("FAIL frame_err: got fe=%0b cv=%0b key=%h, want fe=1 cv=0 key=%h", frame_err, code_valid, key, e.key);
               end
            end else if (!code_valid || frame_err || scancode !== e.sc || key !== e.key) begin
               errors++;
               $display("FAIL byte: got cv=%0b fe=%0b sc=%h key=%h, want cv=1 fe=0 sc=%h key=%h", code_valid, frame_err, scancode, key, e.sc, e.key);
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         wait_cyc(HALF);
         ps2_clk = 1'b0;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      exp_t e;
      logic [3:0] m;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         m = 4'h0;
         if (m_ext && map1.exists(b)) m = map1[b];
         if (!m_ext && map0.exists(b)) m = map0[b];
         if (!m_brk) begin
            if (m != 4'h0) m_key = m;
         end else if (m != 4'h0 && m == m_key) m_key = 4'h0;
         m_brk = 1'b0;
         m_ext = 1'b0;
      end
      e.is_err = 1'b0; e.sc = b; e.key = m_key;
      q.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e.is_err = 1'b1; e.sc = 8'h00; e.key = m_key;
      q.push_back(e);
   endtask

   // bad_par flips the parity bit; stop is the stop-bit value
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par);
      logic par;
      par = (~^b) ^ bad_par;
`ifdef PS2_PARITY_CHECK_EN
      if (!stop || bad_par) push_err(); else model_byte(b);
`else
      if (!stop) push_err(); else model_byte(b);
`endif
      send_bits({stop, par, b, 1'b0}, 11);
      ps2_data = 1'b1;
      wait_cyc(2 * HALF);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (q.size() != 0 && n < 3000) begin
         wait_cyc(1);
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d expectations still pending, want 0", name, q.size());
         q.delete();
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (key !== 4'h0 || scancode !== 8'h00 || code_valid !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL %s: key=%h sc=%h cv=%0b fe=%0b, want all zero", name, key, scancode, code_valid, frame_err);
      end
   endtask

   initial begin
      logic [7:0] pool [12];
      int last_edge, delta, n;
      map0[8'h1C] = 4'h1; map0[8'h23] = 4'h2; map0[8'h1D] = 4'h3; map0[8'h1B] = 4'h4; map0[8'h24] = 4'h5;
      map1[8'h6B] = 4'h1; map1[8'h74] = 4'h2; map1[8'h75] = 4'h3; map1[8'h72] = 4'h4;
      pool = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h24, 8'h6B, 8'h74, 8'h75, 8'h72, 8'hE0, 8'hF0, 8'h00};

      wait_cyc(5);
      @(negedge clk);
      check_zero("reset_outputs");
      rst = 1'b0;
      wait_cyc(10);

      send_frame(8'h23, 1'b1, 1'b0);
      send_frame(8'hF0, 1'b1, 1'b0);
      send_frame(8'h23, 1'b1, 1'b0);
      send_frame(8'hE0, 1'b1, 1'b0);
      send_frame(8'h6B, 1'b1, 1'b0);
      send_frame(8'hE0, 1'b1, 1'b0);
      send_frame(8'hF0, 1'b1, 1'b0);
      send_frame(8'h6B, 1'b1, 1'b0);
      send_frame(8'h1C, 1'b1, 1'b0);
      send_frame(8'h23, 1'b1, 1'b0);
      send_frame(8'hF0, 1'b1, 1'b0);
      send_frame(8'h1C, 1'b1, 1'b0);
      send_frame(8'h55, 1'b0, 1'b0);
      send_frame(8'h1B, 1'b1, 1'b1);
      send_frame(8'h24, 1'b1, 1'b0);
      drain("directed");

      // Timeout: stop after 5 bits, measure from the last raw falling edge.
      push_err();
      send_bits(11'b111_0101_0110, 5);
      last_edge = cyc - HALF;
      n = 0;
      while (!frame_err && n < TO + 200) begin
         @(negedge clk);
         n++;
      end
      delta = cyc - last_edge;
      checks++;
      if (!frame_err || delta < TO || delta > TO + 30) begin
         errors++;
         $display("FAIL timeout: frame_err=%0b after %0d cycles, want 1 within [%0d,%0d]", frame_err, delta, TO, TO + 30);
      end
      wait_cyc(5);
      send_frame(8'h1D, 1'b1, 1'b0);
      drain("timeout");

      // Reset mid-frame with a pending break prefix: both must be discarded.
      send_frame(8'hF0, 1'b1, 1'b0);
      drain("pre_reset");
      send_bits(11'b110_0010_0110, 5);
      rst = 1'b1;
      wait_cyc(3);
      @(negedge clk);
      check_zero("mid_frame_reset");
      m_key = 4'h0; m_brk = 1'b0; m_ext = 1'b0;
      ps2_data = 1'b1;
      wait_cyc(5);
      rst = 1'b0;
      wait_cyc(20);
      send_frame(8'h23, 1'b1, 1'b0);
      drain("post_reset");

      for (int i = 0; i < 40; i++) begin
         logic [7:0] b;
         b = pool[$urandom_range(0, 11)];
         if (b == 8'h00) b = 8'($urandom);
         send_frame(b, ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0));
      end
      drain("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives PS/2 Set-2 scancodes from the keyboard port and drives the 4-bit `key` code consumed by the player movement controller.
- `key` holds the code of the currently pressed mapped key and returns to `key_NONE` when that key is released.
- Sits between the board PS/2 pins and the game logic, in the `clk` domain.

Parameters:
- FILTER_LEN, 8: consecutive equal samples needed before the filtered ps2_clk changes state.
- TIMEOUT_CYCLES, 130000: idle `clk` cycles between falling edges inside a frame before the frame is aborted (2 ms at 65 MHz).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- ps2_clk  input  1  raw PS/2 clock; asynchronous.
- ps2_data  input  1  raw PS/2 data; asynchronous.
- key  output  4  current key code; vga_pkg constants key_NONE=4'h0, key_A=4'h1, key_D=4'h2, key_W=4'h3, key_S=4'h4, key_E=4'h5.
- scancode  output  8  last accepted data byte.
- code_valid  output  1  one-cycle pulse when `scancode` updates.
- frame_err  output  1  one-cycle pulse on a framing, timeout or parity error.

Behaviour:
- Reset: synchronous, active-high, `clk` domain only. During and after reset, every output is zero: `key` = key_NONE, `scancode` = 8'h00, `code_valid` = 0, `frame_err` = 0. The receiver returns to IDLE and the prefix flags `brk` and `ext` clear. Reset mid-frame discards the partial frame.
- Input synchronisation: ps2_clk and ps2_data each pass through a 2-FF synchroniser.
- Clock filter: the filtered clock changes only after FILTER_LEN identical synchronised samples. A falling edge is detected on the 1→0 transition of the filtered clock.
- Frame format: 11 bits, each sampled from synchronised ps2_data on a filtered falling edge.
  - Bit 0: start, must be 0.
  - Bits 1-8: data, LSB first.
  - Bit 9: odd parity.
  - Bit 10: stop, must be 1.
- Receiver FSM, states IDLE, SHIFT, CHECK:
  - IDLE: a falling edge with data=0 enters SHIFT with bit count 1. A falling edge with data=1 is ignored and stays in IDLE; no error.
  - SHIFT: each falling edge stores one bit and increments the count. After the stop bit (count reaches 11) the FSM enters CHECK.
  - Timeout in SHIFT: the timeout counter clears on every falling edge. Reaching TIMEOUT_CYCLES without an edge pulses `frame_err` and returns to IDLE.
  - CHECK, one cycle:
    - Stop bit = 0: pulse `frame_err`, drop the byte.
    - Otherwise: load `scancode` and pulse `code_valid`.
    - Then return to IDLE.
- Latency: `scancode`, `code_valid` and `key` update in the cycle after the stop-bit falling edge is detected.
- Decoder, evaluated on each accepted byte:
  - 8'hE0: set `ext`. `key` unchanged.
  - 8'hF0: set `brk`. `key` unchanged.
  - Any other byte: map it using `ext` (table below), then clear both `brk` and `ext`.
- Map with ext=0: 8'h1C→A, 8'h23→D, 8'h1D→W, 8'h1B→S, 8'h24→E.
- Map with ext=1: 8'h6B→A, 8'h74→D, 8'h75→W, 8'h72→S.
- Make (brk=0):
  - Mapped byte: `key` becomes the mapped code. The newest press wins while another key is held.
  - Unmapped byte: `key` unchanged.
- Break (brk=1):
  - Mapped code equals the current `key`: `key` becomes key_NONE.
  - Otherwise: `key` unchanged.
- Typematic repeats (repeated make codes) re-assert the same `key` value, so `key` does not change.
- An errored frame leaves `key`, `brk` and `ext` unchanged.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: CHECK also verifies odd parity over data+parity. On a mismatch the byte is dropped, `frame_err` pulses, and `code_valid` stays 0.
- Undefined: the parity bit is shifted in and ignored. No parity logic is generated.

Test Plan:
- Send frame 8'h23 with correct parity and stop → `code_valid` pulses once, `scancode`=8'h23, `key`=4'h2.
- Send 8'h23, then 8'hF0, then 8'h23 → `key` goes 4'h2→4'h0 on the third byte; it does not change on the F0 byte.
- Send 8'hE0, 8'h6B, then 8'hE0, 8'hF0, 8'h6B → `key`=4'h1, then 4'h0.
- Press A (8'h1C) then D (8'h23), then release A (F0 1C) → `key` 4'h1→4'h2, and stays 4'h2 after the A release.
- Send a frame with stop=0 → `frame_err` pulses. With PS2_PARITY_CHECK_EN defined, also send a frame with wrong parity → `frame_err` pulses. In both cases `code_valid` stays 0 and `key` is unchanged.
- Stop ps2_clk after 5 bits → `frame_err` pulses TIMEOUT_CYCLES after the last edge, and the next full frame 8'h1D gives `key`=4'h3. Separately, assert `rst` mid-frame → all outputs 0, and the next frame decodes correctly.
